rename_map: RTL

RENAME_MAP -- requirements
Module: rename_map

---
 rtl/rename_map_pkg.sv | 25 ++
 rtl/rename_map_if.sv | 63 ++++++
 rtl/rename_ready_table.sv | 50 +++++
 rtl/rename_map.sv | 123 ++++++++++++
 4 files changed

// File: rtl/rename_map_pkg.sv
// Shared rename types and default widths. Dispatch and the ROB consume rename_pkt_t directly.
package rename_map_pkg;

  localparam int ARCH_REG_BITS_DEF = 5;
  localparam int PHYS_REG_BITS_DEF = 6;

  typedef logic [ARCH_REG_BITS_DEF-1:0] arch_reg_t;
  typedef logic [PHYS_REG_BITS_DEF-1:0] phys_tag_t;

  typedef struct packed {
    phys_tag_t prd;
    phys_tag_t old_prd;
    phys_tag_t prs1;
    phys_tag_t prs2;
    logic      rdy1;
    logic      rdy2;
    logic      has_rd;
  } rename_pkt_t;

  // Writeback tag hit against a looked-up or held source tag.
  function automatic logic tag_hit(logic vld, phys_tag_t a, phys_tag_t b);
    return vld && (a == b);
  endfunction

endpackage

// File: rtl/rename_map_if.sv
// Rename stage bus: decode request, free-list pop, renamed packet, CDB wakeup and commit update.
interface rename_map_if
  import rename_map_pkg::*;
#(
  parameter int ARCH_REG_BITS = ARCH_REG_BITS_DEF,
  parameter int PHYS_REG_BITS = PHYS_REG_BITS_DEF
);
  logic                     flush;

  logic                     dec_valid;
  logic                     dec_ready;
  logic [ARCH_REG_BITS-1:0] dec_rd;
  logic [ARCH_REG_BITS-1:0] dec_rs1;
  logic [ARCH_REG_BITS-1:0] dec_rs2;

  logic                     fl_pop;
  logic                     fl_pop_resp;
  logic [PHYS_REG_BITS-1:0] fl_pop_data;

  logic                     ren_valid;
  logic                     ren_ready;
  logic [PHYS_REG_BITS-1:0] ren_prd;
  logic [PHYS_REG_BITS-1:0] ren_old_prd;
  logic [PHYS_REG_BITS-1:0] ren_prs1;
  logic [PHYS_REG_BITS-1:0] ren_prs2;
  logic                     ren_rdy1;
  logic                     ren_rdy2;
  logic                     ren_has_rd;

  logic                     cdb_valid;
  logic [PHYS_REG_BITS-1:0] cdb_prd;

  logic                     cmt_valid;
  logic [ARCH_REG_BITS-1:0] cmt_rd;
  logic [PHYS_REG_BITS-1:0] cmt_prd;

  modport slave (
    input  flush,
    input  dec_valid, dec_rd, dec_rs1, dec_rs2,
    output dec_ready,
    output fl_pop,
    input  fl_pop_resp, fl_pop_data,
    output ren_valid, ren_prd, ren_old_prd, ren_prs1, ren_prs2,
    output ren_rdy1, ren_rdy2, ren_has_rd,
    input  ren_ready,
    input  cdb_valid, cdb_prd,
    input  cmt_valid, cmt_rd, cmt_prd
  );

  modport master (
    output flush,
    output dec_valid, dec_rd, dec_rs1, dec_rs2,
    input  dec_ready,
    input  fl_pop,
    output fl_pop_resp, fl_pop_data,
    input  ren_valid, ren_prd, ren_old_prd, ren_prs1, ren_prs2,
    input  ren_rdy1, ren_rdy2, ren_has_rd,
    output ren_ready,
    output cdb_valid, cdb_prd,
    output cmt_valid, cmt_rd, cmt_prd
  );

endinterface

// File: rtl/rename_ready_table.sv
// Physical register ready bits: allocation clears, CDB writeback sets, two source lookups.
// With RENAME_CDB_BYPASS_EN a same-cycle CDB hit is folded into the lookups.
module rename_ready_table
  import rename_map_pkg::*;
#(
  parameter int PHYS_REG_BITS = PHYS_REG_BITS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          alloc_en,
  input  logic [PHYS_REG_BITS-1:0]      alloc_tag,
  input  logic                          cdb_valid,
  input  logic [PHYS_REG_BITS-1:0]      cdb_tag,
  input  logic [1:0][PHYS_REG_BITS-1:0] src_tag,
  output logic [1:0]                    src_rdy
);

  localparam int NUM_PHYS = 1 << PHYS_REG_BITS;

  logic [NUM_PHYS-1:0] ready_q, ready_d;

  // Allocation is applied after the CDB set so a same-tag collision ends not-ready.
  always_comb begin
    ready_d = ready_q;
    if (flush) begin
      ready_d = '1;
    end else begin
      if (cdb_valid) ready_d[cdb_tag] = 1'b1;
      if (alloc_en)  ready_d[alloc_tag] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ready_q <= '1;
    else     ready_q <= ready_d;
  end

  always_comb begin
    src_rdy = '0;
    for (int i = 0; i < 2; i++) begin
`ifdef RENAME_CDB_BYPASS_EN
      src_rdy[i] = ready_q[src_tag[i]] | (cdb_valid && (cdb_tag == src_tag[i]));
`else
      src_rdy[i] = ready_q[src_tag[i]];
`endif
    end
  end

endmodule

// File: rtl/rename_map.sv
// Register rename: front/retirement map tables, ready table and one registered output stage.
// Build option RENAME_CDB_BYPASS_EN: same-cycle CDB wakeup of looked-up and held source tags.
module rename_map
  import rename_map_pkg::*;
#(
  parameter int ARCH_REG_BITS = ARCH_REG_BITS_DEF,
  parameter int PHYS_REG_BITS = PHYS_REG_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  rename_map_if.slave bus
);

  localparam int NUM_ARCH = 1 << ARCH_REG_BITS;

  logic [NUM_ARCH-1:0][PHYS_REG_BITS-1:0] front_q, front_d;
  logic [NUM_ARCH-1:0][PHYS_REG_BITS-1:0] ret_q, ret_d;
  rename_pkt_t                            pkt_q, pkt_d;
  logic                                   ren_valid_q, ren_valid_d;

  logic [PHYS_REG_BITS-1:0] prs1, prs2;
  logic [1:0]               tbl_rdy;
  logic                     rs1_zero, rs2_zero, rd_live;
  logic                     slot_free, cdb_block, go, fire, alloc;

  assign rs1_zero = (bus.dec_rs1 == '0);
  assign rs2_zero = (bus.dec_rs2 == '0);
  assign rd_live  = (bus.dec_rd != '0);

  // Sources read the map as it stood before this cycle's rd write.
  assign prs1 = rs1_zero ? '0 : front_q[bus.dec_rs1];
  assign prs2 = rs2_zero ? '0 : front_q[bus.dec_rs2];

`ifdef RENAME_CDB_BYPASS_EN
  assign cdb_block = 1'b0;
`else
  // No bypass path: a wakeup landing on a looked-up tag would be lost, so hold decode off.
  assign cdb_block = (!rs1_zero && tag_hit(bus.cdb_valid, bus.cdb_prd, prs1)) ||
                     (!rs2_zero && tag_hit(bus.cdb_valid, bus.cdb_prd, prs2));
`endif

  assign slot_free = !ren_valid_q || bus.ren_ready;
  assign go        = bus.dec_valid && slot_free && !bus.flush && !cdb_block;
  assign fire      = go && (!rd_live || bus.fl_pop_resp);
  assign alloc     = fire && rd_live;

  assign bus.fl_pop    = go && rd_live;
  assign bus.dec_ready = fire;

  rename_ready_table #(
    .PHYS_REG_BITS(PHYS_REG_BITS)
  ) u_ready (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .alloc_en  (alloc),
    .alloc_tag (bus.fl_pop_data),
    .cdb_valid (bus.cdb_valid),
    .cdb_tag   (bus.cdb_prd),
    .src_tag   ({prs2, prs1}),
    .src_rdy   (tbl_rdy)
  );

  // Commit lands first so a same-cycle flush restores from the updated retirement map.
  always_comb begin
    ret_d   = ret_q;
    front_d = front_q;
    if (bus.cmt_valid && (bus.cmt_rd != '0)) ret_d[bus.cmt_rd] = bus.cmt_prd;
    if (bus.flush)  front_d = ret_d;
    else if (alloc) front_d[bus.dec_rd] = bus.fl_pop_data;
  end

  always_comb begin
    pkt_d       = pkt_q;
    ren_valid_d = ren_valid_q;
    if (bus.flush) begin
      ren_valid_d = 1'b0;
    end else if (fire) begin
      ren_valid_d  = 1'b1;
      pkt_d.prd     = rd_live ? bus.fl_pop_data : '0;
      pkt_d.old_prd = rd_live ? front_q[bus.dec_rd] : '0;
      pkt_d.prs1    = prs1;
      pkt_d.prs2    = prs2;
      pkt_d.rdy1    = rs1_zero | tbl_rdy[0];
      pkt_d.rdy2    = rs2_zero | tbl_rdy[1];
      pkt_d.has_rd  = rd_live;
    end else if (slot_free) begin
      ren_valid_d = 1'b0;
    end else begin
`ifdef RENAME_CDB_BYPASS_EN
      // Held packet still watches the CDB so dispatch sees the wakeup.
      if (tag_hit(bus.cdb_valid, bus.cdb_prd, pkt_q.prs1)) pkt_d.rdy1 = 1'b1;
      if (tag_hit(bus.cdb_valid, bus.cdb_prd, pkt_q.prs2)) pkt_d.rdy2 = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        front_q[i] <= PHYS_REG_BITS'(i);
        ret_q[i]   <= PHYS_REG_BITS'(i);
      end
      pkt_q       <= '0;
      ren_valid_q <= 1'b0;
    end else begin
      front_q     <= front_d;
      ret_q       <= ret_d;
      pkt_q       <= pkt_d;
      ren_valid_q <= ren_valid_d;
    end
  end

  assign bus.ren_valid   = ren_valid_q;
  assign bus.ren_prd     = pkt_q.prd;
  assign bus.ren_old_prd = pkt_q.old_prd;
  assign bus.ren_prs1    = pkt_q.prs1;
  assign bus.ren_prs2    = pkt_q.prs2;
  assign bus.ren_rdy1    = pkt_q.rdy1;
  assign bus.ren_rdy2    = pkt_q.rdy2;
  assign bus.ren_has_rd  = pkt_q.has_rd;

endmodule
